mips_run_monitor: RTL and testbench

- Parametrised run controller and result checker for the pipelined MIPS core; the next generation of the bench-side clock/reset harness.
- Stretches the system reset into a programmable core reset.
- Watches the core's result bus for pass and fail signatures, counts run cycles and enforces a timeout.
- Reports a sticky verdict. Synthesizable, so the same block serves simulation benches and on-board self-test.

---
 rtl/mips_run_monitor.sv | 143 ++++++++++++++
 tb/tb_mips_run_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mips_run_monitor.sv
// Run controller and verdict checker for the pipelined MIPS core.
// It stretches reset into core_reset, then watches result for pass/fail signatures under a cycle timeout.
module mips_run_monitor #(
   parameter int                 WIDTH         = 32,
   parameter int                 CNT_W         = 16,
   parameter int                 RESET_CYCLES  = 2,
   parameter int                 TIMEOUT       = 1000,
   parameter int                 STABLE_CYCLES = 1,
   parameter logic [WIDTH-1:0]   PASS_VALUE    = 32'h00000007,
   parameter logic [WIDTH-1:0]   FAIL_VALUE    = 32'hDEADBEEF,
   parameter bit                 HALT_ON_DONE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] result,
   output logic             core_reset,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [WIDTH-1:0] result_q
);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [7:0]       STABLE_C   = 8'(STABLE_CYCLES);

   state_t           state, state_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic [7:0]       match_cnt, match_cnt_n;
   logic [CNT_W-1:0] cycle_count_n;
   logic [WIDTH-1:0] result_q_n;
   logic             core_reset_n, done_n, pass_n, fail_n, timeout_n;
   logic [CNT_W-1:0] cnt_inc;
   logic [7:0]       match_inc;
   logic             pass_hit;

   // Every output is a flop; the combinational block only computes next values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_HOLD;
         hold_cnt    <= '0;
         match_cnt   <= '0;
         cycle_count <= '0;
         result_q    <= '0;
         core_reset  <= 1'b1;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_n;
         hold_cnt    <= hold_cnt_n;
         match_cnt   <= match_cnt_n;
         cycle_count <= cycle_count_n;
         result_q    <= result_q_n;
         core_reset  <= core_reset_n;
         done        <= done_n;
         pass        <= pass_n;
         fail        <= fail_n;
         timeout     <= timeout_n;
      end
   end

   assign cnt_inc   = cycle_count + 1'b1;
   assign match_inc = match_cnt + 1'b1;

   // Same-edge priority is FAIL over PASS over TIMEOUT; terminal states hold everything.
   always_comb begin
      state_n       = state;
      hold_cnt_n    = hold_cnt;
      match_cnt_n   = match_cnt;
      cycle_count_n = cycle_count;
      result_q_n    = result_q;
      core_reset_n  = core_reset;
      done_n        = done;
      pass_n        = pass;
      fail_n        = fail;
      timeout_n     = timeout;
      pass_hit      = 1'b0;

      case (state)
         ST_HOLD: begin
            core_reset_n = 1'b1;
            hold_cnt_n   = hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               state_n      = ST_RUN;
               core_reset_n = 1'b0;
            end
         end

         ST_RUN: begin
            cycle_count_n = cnt_inc;
            if (result == FAIL_VALUE) begin
               state_n      = ST_FAIL;
               fail_n       = 1'b1;
               done_n       = 1'b1;
               result_q_n   = result;
               core_reset_n = HALT_ON_DONE;
            end else begin
               if (result == PASS_VALUE) begin
                  match_cnt_n = match_inc;
                  pass_hit    = (match_inc == STABLE_C);
               end else begin
                  match_cnt_n = '0;
               end

               if (pass_hit) begin
                  state_n      = ST_PASS;
                  pass_n       = 1'b1;
                  done_n       = 1'b1;
                  result_q_n   = result;
                  core_reset_n = HALT_ON_DONE;
               end else if (cnt_inc == TIMEOUT_C) begin
                  state_n      = ST_TIMEOUT;
                  timeout_n    = 1'b1;
                  done_n       = 1'b1;
                  result_q_n   = result;
                  core_reset_n = HALT_ON_DONE;
               end
            end
         end

         ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            core_reset_n = HALT_ON_DONE;
         end

         default: begin
            state_n = ST_HOLD;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: one default instance driven from a vector table,
// plus STABLE_CYCLES=3 and TIMEOUT=10/HALT_ON_DONE=1 instances for the multi-cycle corners.
module tb_mips_run_monitor;

   logic        clk;
   logic        rst      [3];
   logic [31:0] res      [3];
   logic        cr       [3];
   logic        dn       [3];
   logic        ps       [3];
   logic        fl       [3];
   logic        to       [3];
   logic [15:0] cc       [3];
   logic [31:0] rq       [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic [31:0] res;
      logic [4:0]  flags;
      logic [15:0] cc;
      logic [31:0] rq;
   } vec_t;

   vec_t tbl [16];

   mips_run_monitor u_def (
      .clk(clk), .reset(rst[0]), .result(res[0]), .core_reset(cr[0]), .done(dn[0]),
      .pass(ps[0]), .fail(fl[0]), .timeout(to[0]), .cycle_count(cc[0]), .result_q(rq[0])
   );

   mips_run_monitor #(.STABLE_CYCLES(3)) u_stb (
      .clk(clk), .reset(rst[1]), .result(res[1]), .core_reset(cr[1]), .done(dn[1]),
      .pass(ps[1]), .fail(fl[1]), .timeout(to[1]), .cycle_count(cc[1]), .result_q(rq[1])
   );

   mips_run_monitor #(.TIMEOUT(10), .HALT_ON_DONE(1'b1)) u_halt (
      .clk(clk), .reset(rst[2]), .result(res[2]), .core_reset(cr[2]), .done(dn[2]),
      .pass(ps[2]), .fail(fl[2]), .timeout(to[2]), .cycle_count(cc[2]), .result_q(rq[2])
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkState(input int u, input string name, input logic [4:0] flags,
                             input logic [15:0] cnt, input logic [31:0] rqv);
      checkOutput({name, " flags{cr,done,pass,fail,to}"},
                  {27'd0, cr[u], dn[u], ps[u], fl[u], to[u]}, {27'd0, flags});
      checkOutput({name, " cycle_count"}, {16'd0, cc[u]}, {16'd0, cnt});
      checkOutput({name, " result_q"}, rq[u], rqv);
   endtask

   task automatic applyStimulus(input int u, input logic r, input logic [31:0] v);
      rst[u] = r;
      res[u] = v;
      step();
   endtask

   task automatic startRun(input int u, input string name);
      applyStimulus(u, 1'b1, 32'd0);
      checkState(u, {name, " reset"}, 5'b10000, 16'd0, 32'd0);
      applyStimulus(u, 1'b0, 32'd0);
      checkState(u, {name, " hold1"}, 5'b10000, 16'd0, 32'd0);
      applyStimulus(u, 1'b0, 32'd0);
      checkState(u, {name, " run entry"}, 5'b00000, 16'd0, 32'd0);
   endtask

   task automatic runEdges(input int u, input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) applyStimulus(u, 1'b0, v);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         res[i] = 32'd0;
      end

      tbl[0]  = '{1'b1, 32'h0,        5'b10000, 16'd0, 32'h0};
      tbl[1]  = '{1'b1, 32'h0,        5'b10000, 16'd0, 32'h0};
      tbl[2]  = '{1'b1, 32'h0,        5'b10000, 16'd0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0,        5'b10000, 16'd0, 32'h0};
      tbl[4]  = '{1'b0, 32'h0,        5'b00000, 16'd0, 32'h0};
      tbl[5]  = '{1'b0, 32'h0,        5'b00000, 16'd1, 32'h0};
      tbl[6]  = '{1'b0, 32'h0,        5'b00000, 16'd2, 32'h0};
      tbl[7]  = '{1'b0, 32'h0,        5'b00000, 16'd3, 32'h0};
      tbl[8]  = '{1'b0, 32'h0,        5'b00000, 16'd4, 32'h0};
      tbl[9]  = '{1'b0, 32'h7,        5'b01100, 16'd5, 32'h7};
      tbl[10] = '{1'b0, 32'hDEADBEEF, 5'b01100, 16'd5, 32'h7};
      tbl[11] = '{1'b0, 32'h1234,     5'b01100, 16'd5, 32'h7};
      tbl[12] = '{1'b1, 32'h7,        5'b10000, 16'd0, 32'h0};
      tbl[13] = '{1'b0, 32'hDEADBEEF, 5'b10000, 16'd0, 32'h0};
      tbl[14] = '{1'b0, 32'hDEADBEEF, 5'b00000, 16'd0, 32'h0};
      tbl[15] = '{1'b0, 32'hDEADBEEF, 5'b01010, 16'd1, 32'hDEADBEEF};

      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, tbl[i].rst, tbl[i].res);
         checkState(0, $sformatf("vec%0d", i), tbl[i].flags, tbl[i].cc, tbl[i].rq);
      end

      // Timeout on the default instance at exactly RUN edge 1000.
      startRun(0, "to1000");
      runEdges(0, 999, 32'd0);
      checkState(0, "to1000 edge999", 5'b00000, 16'd999, 32'd0);
      applyStimulus(0, 1'b0, 32'd0);
      checkState(0, "to1000 edge1000", 5'b01001, 16'd1000, 32'd0);

      // Reset asserted on RUN edge 50, then the HOLD sequence again.
      startRun(0, "midrun");
      runEdges(0, 49, 32'd0);
      checkState(0, "midrun edge49", 5'b00000, 16'd49, 32'd0);
      applyStimulus(0, 1'b1, 32'h7);
      checkState(0, "midrun reset", 5'b10000, 16'd0, 32'd0);
      applyStimulus(0, 1'b0, 32'd0);
      checkState(0, "midrun hold1", 5'b10000, 16'd0, 32'd0);
      applyStimulus(0, 1'b0, 32'd0);
      checkState(0, "midrun hold2", 5'b00000, 16'd0, 32'd0);
      applyStimulus(0, 1'b0, 32'd0);
      checkState(0, "midrun edge1", 5'b00000, 16'd1, 32'd0);

      // STABLE_CYCLES=3: a broken pair must not pass; three in a row must.
      startRun(1, "stable");
      runEdges(1, 2, 32'h7);
      checkState(1, "stable pair", 5'b00000, 16'd2, 32'd0);
      runEdges(1, 1, 32'h0);
      runEdges(1, 2, 32'h7);
      checkState(1, "stable edge5", 5'b00000, 16'd5, 32'd0);
      applyStimulus(1, 1'b0, 32'h7);
      checkState(1, "stable edge6", 5'b01100, 16'd6, 32'h7);

      // Fail signature on RUN edge 4 after a partial match.
      startRun(1, "partfail");
      runEdges(1, 1, 32'h0);
      runEdges(1, 2, 32'h7);
      applyStimulus(1, 1'b0, 32'hDEADBEEF);
      checkState(1, "partfail edge4", 5'b01010, 16'd4, 32'hDEADBEEF);

      // TIMEOUT=10 with halt: pass on the timeout edge wins and core_reset re-asserts.
      startRun(2, "halt");
      runEdges(2, 9, 32'd0);
      checkState(2, "halt edge9", 5'b00000, 16'd9, 32'd0);
      applyStimulus(2, 1'b0, 32'h7);
      checkState(2, "halt pass edge10", 5'b11100, 16'd10, 32'h7);
      applyStimulus(2, 1'b0, 32'hDEADBEEF);
      checkState(2, "halt sticky", 5'b11100, 16'd10, 32'h7);

      startRun(2, "halt2");
      runEdges(2, 10, 32'h5);
      checkState(2, "halt2 timeout", 5'b11001, 16'd10, 32'h5);
      startRun(2, "halt3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
